// File: rtl/imm_pkg.sv
// Shared types and constants for the decode-stage immediate extension path.
// Mode encodings, MIPS opcode constants and the buffered entry layout.
package imm_pkg;

    localparam int DEPTH = 2;
    localparam int OPW   = 6;

    typedef enum logic [1:0] {
        MODE_NONE = 2'b00,
        MODE_ZERO = 2'b01,
        MODE_SIGN = 2'b10,
        MODE_LUI  = 2'b11
    } mode_e;

    localparam logic [OPW-1:0] OP_REGIMM = 6'h01;
    localparam logic [OPW-1:0] OP_BEQ    = 6'h04;
    localparam logic [OPW-1:0] OP_BNE    = 6'h05;
    localparam logic [OPW-1:0] OP_BLEZ   = 6'h06;
    localparam logic [OPW-1:0] OP_BGTZ   = 6'h07;
    localparam logic [OPW-1:0] OP_ADDI   = 6'h08;
    localparam logic [OPW-1:0] OP_ADDIU  = 6'h09;
    localparam logic [OPW-1:0] OP_SLTI   = 6'h0A;
    localparam logic [OPW-1:0] OP_SLTIU  = 6'h0B;
    localparam logic [OPW-1:0] OP_ANDI   = 6'h0C;
    localparam logic [OPW-1:0] OP_ORI    = 6'h0D;
    localparam logic [OPW-1:0] OP_XORI   = 6'h0E;
    localparam logic [OPW-1:0] OP_LUI    = 6'h0F;
    localparam logic [OPW-1:0] OP_LB     = 6'h20;
    localparam logic [OPW-1:0] OP_LH     = 6'h21;
    localparam logic [OPW-1:0] OP_LW     = 6'h23;
    localparam logic [OPW-1:0] OP_SB     = 6'h28;
    localparam logic [OPW-1:0] OP_SH     = 6'h29;
    localparam logic [OPW-1:0] OP_SW     = 6'h2B;

    typedef struct packed {
        logic [31:0] instr;
        mode_e       mode;
        logic [31:0] imm;
        logic [31:0] br_off;
    } entry_t;

    function automatic mode_e decode_mode(input logic [OPW-1:0] op);
        mode_e m;
        unique case (op)
            OP_ANDI, OP_ORI, OP_XORI: m = MODE_ZERO;
            OP_REGIMM, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ,
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_LB, OP_LH, OP_LW, OP_SB, OP_SH, OP_SW: m = MODE_SIGN;
            OP_LUI:  m = MODE_LUI;
            default: m = MODE_NONE;
        endcase
        return m;
    endfunction

    function automatic logic is_branch(input logic [OPW-1:0] op);
        return (op == OP_REGIMM) || (op >= OP_BEQ && op <= OP_BGTZ);
    endfunction

endpackage

// File: rtl/SignExtension_16Bit_to_32_bit.sv
// 16-to-32-bit extension unit: ext_sel=1 sign-extends, ext_sel=0 zero-extends.
module SignExtension_16Bit_to_32_bit (
    input  logic [15:0] imm16,
    input  logic        ext_sel,
    output logic [31:0] imm32
);

    assign imm32 = {{16{ext_sel & imm16[15]}}, imm16};

endmodule

// File: rtl/imm_skid_buffer.sv
// Two-entry FIFO with registered in_ready and flush; head entry always on dout.
module imm_skid_buffer
    import imm_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         flush,
    input  logic         in_valid,
    input  logic [W-1:0] din,
    output logic         in_ready,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] dout
);

    logic [1:0]   count;
    logic [1:0]   count_next;
    logic [W-1:0] e0;
    logic [W-1:0] e1;
    logic         push;
    logic         pop;

    assign push      = in_valid && in_ready;
    assign pop       = (count != 2'd0) && out_ready;
    assign out_valid = (count != 2'd0);
    assign dout      = e0;

    always_comb begin
        count_next = count;
        if (flush) begin
            count_next = 2'd0;
        end else begin
            unique case ({push, pop})
                2'b10:   count_next = count + 2'd1;
                2'b01:   count_next = count - 2'd1;
                default: count_next = count;
            endcase
        end
    end

    // e0 keeps its contents when the buffer empties so outputs hold
    always_ff @(posedge Clk) begin
        if (Rst) begin
            count    <= 2'd0;
            in_ready <= 1'b0;
            e0       <= '0;
            e1       <= '0;
        end else begin
            count    <= count_next;
            in_ready <= (count_next < 2'(DEPTH));
            if (!flush) begin
                if (pop && count == 2'd2) begin
                    e0 <= e1;
                end
                if (push) begin
                    if (count == 2'd0 || (count == 2'd1 && pop)) begin
                        e0 <= din;
                    end else begin
                        e1 <= din;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/imm_extend_stage.sv
// Decode-stage immediate extension: opcode decode, extension unit control,
// and a two-entry skid buffer toward the ID/EX boundary.
module imm_extend_stage
    import imm_pkg::*;
(
    input  logic        Clk,
    input  logic        Rst,
    input  logic        in_valid,
    input  logic [31:0] in_instr,
    output logic        in_ready,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [1:0]  out_mode,
    output logic [31:0] out_imm,
    output logic [31:0] out_br_off
);

    logic [OPW-1:0] op;
    mode_e          mode;
    logic           ext_sel;
    logic [31:0]    ext_out;
    entry_t         din;
    entry_t         head;

    assign op      = in_instr[31:32-OPW];
    assign mode    = decode_mode(op);
    assign ext_sel = (mode == MODE_SIGN);

    SignExtension_16Bit_to_32_bit u_ext (
        .imm16   (in_instr[15:0]),
        .ext_sel (ext_sel),
        .imm32   (ext_out)
    );

    always_comb begin
        din       = '0;
        din.instr = in_instr;
        din.mode  = mode;
        unique case (mode)
            MODE_ZERO, MODE_SIGN: din.imm = ext_out;
            MODE_LUI:             din.imm = {in_instr[15:0], 16'h0000};
            default:              din.imm = '0;
        endcase
        din.br_off = is_branch(op) ? {ext_out[29:0], 2'b00} : 32'd0;
    end

    imm_skid_buffer #(
        .W ($bits(entry_t))
    ) u_buf (
        .Clk       (Clk),
        .Rst       (Rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .din       (din),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (head)
    );

    assign out_instr  = head.instr;
    assign out_mode   = head.mode;
    assign out_imm    = head.imm;
    assign out_br_off = head.br_off;

endmodule

// File: tb/tb_imm_extend_stage.sv
// Randomized and directed bench for imm_extend_stage against a queue model.
module tb_imm_extend_stage;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        in_valid;
    logic [31:0] in_instr;
    logic        in_ready;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [1:0]  out_mode;
    logic [31:0] out_imm;
    logic [31:0] out_br_off;

    imm_extend_stage dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .in_valid   (in_valid),
        .in_instr   (in_instr),
        .in_ready   (in_ready),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_mode   (out_mode),
        .out_imm    (out_imm),
        .out_br_off (out_br_off)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [31:0] instr;
        logic [1:0]  mode;
        logic [31:0] imm;
        logic [31:0] br;
    } ent_t;

    ent_t q[$];
    ent_t last;
    bit   mready;
    int   checks;
    int   failures;

    function automatic ent_t ref_entry(input logic [31:0] w);
        ent_t e;
        int unsigned op;
        logic [31:0] sx;
        op = int'(w[31:26]);
        sx = 32'($signed(w[15:0]));
        e.instr = w;
        e.br = 32'd0;
        if (op inside {12, 13, 14}) begin
            e.mode = 2'd1;
            e.imm = 32'(w[15:0]);
        end else if (op inside {1, [4:11], 32, 33, 35, 40, 41, 43}) begin
            e.mode = 2'd2;
            e.imm = sx;
        end else if (op == 15) begin
            e.mode = 2'd3;
            e.imm = 32'(w[15:0]) * 32'd65536;
        end else begin
            e.mode = 2'd0;
            e.imm = 32'd0;
        end
        if (op == 1 || (op >= 4 && op <= 7)) e.br = sx * 32'd4;
        return e;
    endfunction

    function automatic logic [99:0] got();
        return {out_valid, in_ready, out_instr, out_mode, out_imm, out_br_off};
    endfunction

    function automatic logic [99:0] exp_vec();
        return {q.size() != 0, mready, last.instr, last.mode, last.imm, last.br};
    endfunction

    task automatic cycle(input bit rst, input bit v, input logic [31:0] w,
                         input bit ordy, input bit fl);
        bit acc;
        bit pop;
        Rst = rst;
        in_valid = v;
        in_instr = w;
        out_ready = ordy;
        flush = fl;
        if (rst) begin
            q.delete();
            last = '{32'd0, 2'd0, 32'd0, 32'd0};
            mready = 1'b0;
        end else begin
            acc = v && mready;
            pop = (q.size() != 0) && ordy;
            if (fl) begin
                q.delete();
            end else begin
                if (pop) void'(q.pop_front());
                if (acc) q.push_back(ref_entry(w));
            end
            mready = (q.size() < 2);
            if (q.size() != 0) last = q[0];
        end
        @(negedge Clk);
    endtask

    task automatic test_reset();
        cycle(1, 1, 32'h2008FFFF, 1, 0);
        cycle(1, 0, 32'd0, 0, 0);
        checks++;
        if (got() !== 100'd0 || got() !== exp_vec()) begin
            failures++;
            $display("FAIL reset_state: got %h want %h", got(), exp_vec());
        end
        cycle(0, 0, 32'd0, 0, 0);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b want 1 0",
                     in_ready, out_valid);
        end
    endtask

    task automatic test_directed();
        logic [31:0] w [5] = '{32'h2008FFFF, 32'h3508FFFF, 32'h3C081234,
                               32'h1109FFFE, 32'h01095020};
        logic [1:0]  m [5] = '{2'b10, 2'b01, 2'b11, 2'b10, 2'b00};
        logic [31:0] im [5] = '{32'hFFFFFFFF, 32'h0000FFFF, 32'h12340000,
                                32'hFFFFFFFE, 32'h00000000};
        logic [31:0] bo [5] = '{32'h0, 32'h0, 32'h0, 32'hFFFFFFF8, 32'h0};
        for (int i = 0; i < 5; i++) begin
            cycle(0, 1, w[i], 1, 0);
            checks++;
            if ({out_valid, out_instr, out_mode, out_imm, out_br_off} !==
                {1'b1, w[i], m[i], im[i], bo[i]}) begin
                failures++;
                $display("FAIL directed_%0d: got v=%b i=%h m=%b imm=%h br=%h",
                         i, out_valid, out_instr, out_mode, out_imm, out_br_off);
            end
            checks++;
            if (got() !== exp_vec()) begin
                failures++;
                $display("FAIL directed_model_%0d: got %h want %h", i, got(), exp_vec());
            end
        end
        cycle(0, 0, 32'd0, 1, 0);
        checks++;
        if (out_valid !== 1'b0 || out_instr !== 32'h01095020) begin
            failures++;
            $display("FAIL drain_hold: v=%b instr=%h want 0 01095020",
                     out_valid, out_instr);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] w [3] = '{32'h21290001, 32'h3129F0F0, 32'h8D2A0010};
        cycle(0, 1, w[0], 0, 0);
        cycle(0, 1, w[1], 0, 0);
        checks++;
        if (in_ready !== 1'b0 || out_instr !== w[0] || got() !== exp_vec()) begin
            failures++;
            $display("FAIL bp_full: ready=%b head=%h want 0 %h", in_ready, out_instr, w[0]);
        end
        cycle(0, 1, w[2], 1, 0);
        checks++;
        if (out_instr !== w[1] || in_ready !== 1'b1 || got() !== exp_vec()) begin
            failures++;
            $display("FAIL bp_pop1: head=%h ready=%b want %h 1", out_instr, in_ready, w[1]);
        end
        cycle(0, 1, w[2], 1, 0);
        checks++;
        if (out_instr !== w[2] || out_valid !== 1'b1 || got() !== exp_vec()) begin
            failures++;
            $display("FAIL bp_third: head=%h v=%b want %h 1", out_instr, out_valid, w[2]);
        end
        cycle(0, 0, 32'd0, 1, 0);
        checks++;
        if (out_valid !== 1'b0 || got() !== exp_vec()) begin
            failures++;
            $display("FAIL bp_drain: got %h want %h", got(), exp_vec());
        end
    endtask

    task automatic test_flush();
        cycle(0, 1, 32'h24010005, 0, 0);
        cycle(0, 1, 32'h24020006, 0, 0);
        cycle(0, 1, 32'h2403BEEF, 1, 1);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL flush: v=%b ready=%b want 0 1", out_valid, in_ready);
        end
        cycle(0, 0, 32'd0, 1, 0);
        checks++;
        if (out_valid !== 1'b0 || out_instr === 32'h2403BEEF || got() !== exp_vec()) begin
            failures++;
            $display("FAIL flush_drop: got %h want %h", got(), exp_vec());
        end
    endtask

    task automatic test_reset_mid();
        cycle(0, 1, 32'h3C01ABCD, 0, 0);
        cycle(1, 1, 32'h3C02ABCD, 0, 0);
        checks++;
        if (got() !== 100'd0) begin
            failures++;
            $display("FAIL reset_mid: got %h want 0", got());
        end
        cycle(1, 1, 32'h3C03ABCD, 1, 0);
        cycle(0, 1, 32'h3C04ABCD, 1, 0);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || got() !== exp_vec()) begin
            failures++;
            $display("FAIL reset_mid_release: got %h want %h", got(), exp_vec());
        end
    endtask

    task automatic test_random();
        logic [31:0] w;
        for (int i = 0; i < 400; i++) begin
            w = $urandom;
            if ($urandom_range(0, 1) == 0) w[31:26] = 6'($urandom_range(0, 15));
            cycle(0, $urandom_range(0, 3) != 0, w, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 15) == 0);
            checks++;
            if (got() !== exp_vec()) begin
                failures++;
                $display("FAIL random_%0d: got %h want %h", i, got(), exp_vec());
            end
        end
    endtask

    initial begin
        Rst = 1'b1;
        in_valid = 1'b0;
        in_instr = 32'd0;
        out_ready = 1'b0;
        flush = 1'b0;
        checks = 0;
        failures = 0;
        mready = 1'b0;
        last = '{32'd0, 2'd0, 32'd0, 32'd0};
        @(negedge Clk);
        test_reset();
        test_directed();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imm_extend_stage.md
Name: imm_extend_stage

Overview:
- Decode-stage sequencer that owns the 16-to-32-bit extension unit.
- Accepts fetched instruction words over a valid/ready handshake and decodes the opcode to pick zero-extend, sign-extend, LUI placement or none.
- Drives the extension unit's control input and registers the extended immediate plus branch offset toward the ID/EX boundary.
- A 2-entry skid buffer absorbs back-pressure from execute, so fetch sees a registered ready.

Parameters:
- DEPTH, 2, skid buffer entries; fixed at 2 in this revision.
- OPW, 6, opcode field width, bits [31:26].

Ports:
- Clk  in  1  rising-edge clock.
- Rst  in  1  synchronous reset, active-high.
- in_valid  in  1  instruction word presented.
- in_instr  in  32  MIPS instruction word.
- in_ready  out  1  stage can accept this cycle; registered.
- flush  in  1  discard all buffered entries (branch taken / exception).
- out_valid  out  1  head entry valid.
- out_ready  in  1  execute consumes head entry.
- out_instr  out  32  instruction of head entry.
- out_mode  out  2  00 NONE, 01 ZERO, 10 SIGN, 11 LUI.
- out_imm  out  32  extended immediate.
- out_br_off  out  32  sign-extended imm shifted left 2; 0 for non-branch.

Behaviour:
- Clock and reset: one clock, Clk. Rst is synchronous and active-high.
- Reset (Clk edge with Rst=1): buffer empty; out_valid=0; out_instr, out_imm and out_br_off = 0; out_mode = 00. in_ready=0 while Rst is high and =1 from the first cycle after.
- Decode is combinational on in_instr[31:26]; the result is stored with the entry at accept.
  - ZERO: 0x0C, 0x0D, 0x0E (andi, ori, xori). Extension control = 0.
  - SIGN: 0x01, 0x04-0x0B, 0x20, 0x21, 0x23, 0x28, 0x29, 0x2B. Extension control = 1.
  - LUI: 0x0F. out_imm = {imm, 16'h0000}; no extension unit use.
  - NONE: all other opcodes (0x00 R-type, 0x02 j, 0x03 jal, unknown). out_imm = 0.
  - out_br_off = {sext[29:0], 2'b00} only for 0x01 and 0x04-0x07; otherwise 0.
- Accept when in_valid && in_ready; pop when out_valid && out_ready.
- Latency: a word accepted at edge N appears on outputs after edge N (out_valid=1 in cycle N+1) when the buffer was empty. Order is strictly FIFO.
- Occupancy count 0..2:
  - in_ready(next) = (count_next < 2).
  - out_valid = (count != 0).
  - Push and pop in the same cycle leave count unchanged; the data shifts correctly.
  - At count = 2, in_ready = 0 and nothing is accepted, even if a pop occurs that cycle. in_ready rises the following cycle.
- Outputs always show the head entry. When count = 0, outputs hold their last values with out_valid = 0.
- flush: count goes to 0 at the edge and in_ready = 1 next cycle.
  - Flush beats a simultaneous accept (the word is dropped) and a simultaneous pop.
  - Rst beats flush.
- Reset mid-operation: all entries are dropped with no partial output. Same as the reset state above.
- No arithmetic overflow is possible. All widths are exactly as listed.

Decomposition:
- Shared package (imm_pkg):
  - Mode encodings MODE_NONE/ZERO/SIGN/LUI.
  - Opcode constants: OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_ADDI, OP_BEQ, etc.
  - Entry struct {instr, mode, imm, br_off}.
- Sub-module imm_skid_buffer: generic 2-entry FIFO with count, in_ready and flush.
- The top level holds the decoder and one instance of the existing SignExtension_16Bit_to_32_bit unit, whose control input is driven from mode == SIGN.

Test Plan:
- Reset, then push addi 0x2008FFFF with out_ready=1 -> next cycle out_valid=1, mode=10, imm=0xFFFFFFFF, br_off=0.
- Push ori 0x3508FFFF -> mode=01, imm=0x0000FFFF. Then push lui 0x3C081234 -> mode=11, imm=0x12340000.
- Push beq 0x1109FFFE -> mode=10, imm=0xFFFFFFFE, br_off=0xFFFFFFF8. Then R-type 0x01095020 -> mode=00, imm=0, br_off=0.
- out_ready=0 with 3 words pushed back-to-back:
  - Required: first two accepted; in_ready=0 from the cycle after the second accept.
  - Then raise out_ready: the words emerge in order, in_ready returns, and the third word is accepted.
- Buffer holding 2 entries, assert flush together with in_valid and out_ready -> next cycle out_valid=0, in_ready=1, and the flushed-cycle word never appears.
- Assert Rst while 1 entry is buffered and push continues -> out_valid=0, outputs 0, in_ready=0 during Rst, =1 one cycle after.
